// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU pipeline controller: FSM state encoding and
// branch-strategy codes.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] BP_NOT_TAKEN  = 2'b00;
  localparam logic [1:0] BP_TAKEN      = 2'b01;
  localparam logic [1:0] BP_DELAY_SLOT = 2'b10;

  // Only not-taken and delay-slot strategies are implemented.
  function automatic logic bp_unsupported(input logic [1:0] mode);
    logic res;
    case (mode)
      BP_NOT_TAKEN:  res = 1'b0;
      BP_DELAY_SLOT: res = 1'b0;
      BP_TAKEN:      res = 1'b1;
      default:       res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_count <= '0;
    end else if (i_en && (o_count != '1)) begin
      o_count <= o_count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stalls, redirect
// flushes, memory wait freezes, drain-and-halt, and performance counters.
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_PC      = 32'd88,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       bp_mode,
  input  logic [31:0]      fetch_pc,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic             bp_mode_err,
  output logic [CNT_W-1:0] cnt_cycles,
  output logic [CNT_W-1:0] cnt_stalls,
  output logic [CNT_W-1:0] cnt_flushes
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  ctrl_state_e        r_state;
  ctrl_state_e        r_prior;
  logic [DRAIN_W-1:0] r_drain;

  ctrl_state_e        w_state_nxt;
  ctrl_state_e        w_prior_nxt;
  logic [DRAIN_W-1:0] w_drain_nxt;
  ctrl_state_e        w_eff;
  logic               w_wait;
  logic               w_load_use;
  logic               w_delay_slot;
  logic               w_stall_evt;
  logic               w_flush_evt;
  logic               w_cycle_evt;

  // Hazard conditions decoded from the current pipeline contents.
  always_comb begin
    w_wait       = !imem_ready || !dmem_ready;
    w_load_use   = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_rd)) ||
                    (id_uses_rt && (id_rt == ex_rd)));
    w_delay_slot = (bp_mode == BP_DELAY_SLOT);
    // A wait cycle that clears behaves as the state it interrupted.
    w_eff        = (r_state == MEM_WAIT) ? r_prior : r_state;
    bp_mode_err  = bp_unsupported(bp_mode);
    halted       = (r_state == HALTED);
    w_cycle_evt  = (r_state != HALTED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_prior <= RUN;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prior <= w_prior_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Next state and stage controls; priority wait > redirect > load-use > drain.
  always_comb begin
    w_state_nxt = w_eff;
    w_prior_nxt = r_prior;
    w_drain_nxt = r_drain;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    w_stall_evt = 1'b0;
    w_flush_evt = 1'b0;

    if (w_eff == HALTED) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (w_wait) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      w_stall_evt = 1'b1;
      w_state_nxt = MEM_WAIT;
      w_prior_nxt = w_eff;
    end else if (ex_branch_taken || id_jump) begin
      if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = !w_delay_slot;
        w_flush_evt = 1'b1;
      end else begin
        ifid_flush  = !w_delay_slot;
        w_flush_evt = !w_delay_slot;
      end
      w_state_nxt = RUN;
      w_drain_nxt = '0;
    end else if (w_load_use) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_flush  = 1'b1;
      w_stall_evt = 1'b1;
      if (w_eff == DRAIN) begin
        if (r_drain <= DRAIN_W'(1)) begin
          w_state_nxt = HALTED;
          w_drain_nxt = '0;
        end else begin
          w_drain_nxt = r_drain - DRAIN_W'(1);
        end
      end
    end else if (w_eff == DRAIN) begin
      pc_we      = 1'b0;
      ifid_flush = 1'b1;
      if (r_drain <= DRAIN_W'(1)) begin
        w_state_nxt = HALTED;
        w_drain_nxt = '0;
      end else begin
        w_drain_nxt = r_drain - DRAIN_W'(1);
      end
    end else if (fetch_pc == HALT_PC) begin
      w_state_nxt = DRAIN;
      w_drain_nxt = DRAIN_W'(DRAIN_CYCLES);
    end

    // While reset is held the pipeline free-runs with no bubbles.
    if (!rst) begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      w_stall_evt = 1'b0;
      w_flush_evt = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_cycles (
    .clk     (clk),
    .rst_n   (rst),
    .i_en    (w_cycle_evt),
    .o_count (cnt_cycles)
  );

  sat_counter #(.W(CNT_W)) u_cnt_stalls (
    .clk     (clk),
    .rst_n   (rst),
    .i_en    (w_stall_evt),
    .o_count (cnt_stalls)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flushes (
    .clk     (clk),
    .rst_n   (rst),
    .i_en    (w_flush_evt),
    .o_count (cnt_flushes)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed table-driven bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  bp_mode = 2'b00;
  logic [31:0] fetch_pc = 32'd40;
  logic [4:0]  id_rs = 5'd1, id_rt = 5'd2, ex_rd = 5'd0;
  logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_jump = 1'b0;
  logic        ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic        imem_ready = 1'b1, dmem_ready = 1'b1;
  logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic        ifid_flush, idex_flush, halted, bp_mode_err;
  logic [31:0] cnt_cycles, cnt_stalls, cnt_flushes;

  int n_total = 0;
  int n_bad   = 0;

  // {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush}
  localparam logic [6:0] ALL    = 7'b11111_00;
  localparam logic [6:0] FROZEN = 7'b00000_00;
  localparam logic [6:0] LU     = 7'b00111_01;
  localparam logic [6:0] FL2    = 7'b11111_11;
  localparam logic [6:0] FL1    = 7'b11111_10;
  localparam logic [6:0] DRN    = 7'b01111_10;

  typedef struct {
    logic [1:0]  bp;
    logic [31:0] pc;
    logic        mrd;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic        urs;
    logic [4:0]  rt;
    logic        urt;
    logic        jmp;
    logic        br;
    logic        ir;
    logic        dr;
    logic [6:0]  ctl;
    logic        hlt;
    logic        err;
    int          cyc;
    int          st;
    int          fl;
  } vec_t;

  vec_t tbl[23];

  pipeline_hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .bp_mode         (bp_mode),
    .fetch_pc        (fetch_pc),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_jump         (id_jump),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .imem_ready      (imem_ready),
    .dmem_ready      (dmem_ready),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .idex_we         (idex_we),
    .exmem_we        (exmem_we),
    .memwb_we        (memwb_we),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .halted          (halted),
    .bp_mode_err     (bp_mode_err),
    .cnt_cycles      (cnt_cycles),
    .cnt_stalls      (cnt_stalls),
    .cnt_flushes     (cnt_flushes)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [1:0] bp, input logic [31:0] pc,
    input logic mrd, input logic [4:0] rd,
    input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
    input logic jmp, input logic br, input logic ir, input logic dr,
    input logic [6:0] ctl, input logic hlt, input logic err,
    input int cyc, input int st, input int fl);
    vec_t v;
    v.bp = bp; v.pc = pc; v.mrd = mrd; v.rd = rd; v.rs = rs; v.urs = urs;
    v.rt = rt; v.urt = urt; v.jmp = jmp; v.br = br; v.ir = ir; v.dr = dr;
    v.ctl = ctl; v.hlt = hlt; v.err = err; v.cyc = cyc; v.st = st; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bp_mode = v.bp; fetch_pc = v.pc; ex_mem_read = v.mrd; ex_rd = v.rd;
    id_rs = v.rs; id_uses_rs = v.urs; id_rt = v.rt; id_uses_rt = v.urt;
    id_jump = v.jmp; ex_branch_taken = v.br; imem_ready = v.ir; dmem_ready = v.dr;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, ".ctl"}, 32'({pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush}),
        32'(v.ctl));
    chk({tag, ".halted"}, 32'(halted), 32'(v.hlt));
    chk({tag, ".bp_err"}, 32'(bp_mode_err), 32'(v.err));
    chk({tag, ".cycles"}, cnt_cycles, 32'(v.cyc));
    chk({tag, ".stalls"}, cnt_stalls, 32'(v.st));
    chk({tag, ".flushes"}, cnt_flushes, 32'(v.fl));
  endtask

  // One clock cycle with reset released: drive at negedge, sample 1ns later.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    rst = 1'b1;
    drive(v);
    #1;
    check_outs(tag, v);
  endtask

  // Assert reset mid-cycle with hazardous inputs applied.
  task automatic reset_check(input string tag);
    vec_t v;
    @(negedge clk);
    v = mk(2'b00, 32'd88, 1, 5'd9, 5'd9, 1, 5'd0, 0, 1, 0, 0, 1, ALL, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(v);
    #1;
    check_outs(tag, v);
  endtask

  initial begin
    tbl[0]  = mk(2'b00, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 0, 0, 1, 1, ALL,    0, 0,  0, 0, 0);
    tbl[1]  = mk(2'b00, 32'd40, 1, 5'd20, 5'd20, 1, 5'd2, 0, 0, 0, 1, 1, LU,     0, 0,  1, 0, 0);
    tbl[2]  = mk(2'b00, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 0, 0, 1, 1, ALL,    0, 0,  2, 1, 0);
    tbl[3]  = mk(2'b00, 32'd40, 1, 5'd7,  5'd1,  1, 5'd7, 1, 0, 0, 1, 1, LU,     0, 0,  3, 1, 0);
    tbl[4]  = mk(2'b00, 32'd40, 1, 5'd0,  5'd0,  1, 5'd0, 1, 0, 0, 1, 1, ALL,    0, 0,  4, 2, 0);
    tbl[5]  = mk(2'b00, 32'd40, 1, 5'd20, 5'd20, 0, 5'd20, 0, 0, 0, 1, 1, ALL,   0, 0,  5, 2, 0);
    tbl[6]  = mk(2'b00, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 0, 1, 1, 1, FL2,    0, 0,  6, 2, 0);
    tbl[7]  = mk(2'b00, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 0, 0, 1, 1, ALL,    0, 0,  7, 2, 1);
    tbl[8]  = mk(2'b10, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 0, 1, 1, 1, FL1,    0, 0,  8, 2, 1);
    tbl[9]  = mk(2'b00, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 1, 0, 1, 1, FL1,    0, 0,  9, 2, 2);
    tbl[10] = mk(2'b10, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 1, 0, 1, 1, ALL,    0, 0, 10, 2, 3);
    tbl[11] = mk(2'b00, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 1, 1, 1, 1, FL2,    0, 0, 11, 2, 3);
    tbl[12] = mk(2'b01, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 0, 1, 1, 1, FL2,    0, 1, 12, 2, 4);
    tbl[13] = mk(2'b00, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 1, 0, 0, 1, FROZEN, 0, 0, 13, 2, 5);
    tbl[14] = mk(2'b00, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 1, 0, 0, 1, FROZEN, 0, 0, 14, 3, 5);
    tbl[15] = mk(2'b00, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 1, 0, 0, 1, FROZEN, 0, 0, 15, 4, 5);
    tbl[16] = mk(2'b00, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 1, 0, 1, 1, FL1,    0, 0, 16, 5, 5);
    tbl[17] = mk(2'b00, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 0, 0, 1, 1, ALL,    0, 0, 17, 5, 6);
    tbl[18] = mk(2'b00, 32'd40, 1, 5'd20, 5'd20, 1, 5'd2, 0, 0, 0, 1, 0, FROZEN, 0, 0, 18, 5, 6);
    tbl[19] = mk(2'b00, 32'd40, 1, 5'd20, 5'd20, 1, 5'd2, 0, 0, 0, 1, 1, LU,     0, 0, 19, 6, 6);
    tbl[20] = mk(2'b00, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 0, 0, 1, 1, ALL,    0, 0, 20, 7, 6);
    tbl[21] = mk(2'b11, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 1, 0, 1, 1, FL1,    0, 1, 21, 7, 6);
    tbl[22] = mk(2'b00, 32'd40, 0, 5'd0,  5'd1,  0, 5'd2, 0, 0, 0, 1, 1, ALL,    0, 0, 22, 7, 7);

    reset_check("rst0");
    for (int i = 0; i < 23; i++) begin
      apply($sformatf("row%0d", i), tbl[i]);
    end

    // Drain and halt from HALT_PC, then sticky HALTED with frozen counters.
    apply("drain_entry", mk(2'b00, 32'd88, 0, 5'd0, 5'd1, 0, 5'd2, 0, 0, 0, 1, 1, ALL, 0, 0, 23, 7, 7));
    for (int i = 0; i < 4; i++) begin
      apply($sformatf("drain%0d", i),
            mk(2'b00, 32'd88, 0, 5'd0, 5'd1, 0, 5'd2, 0, 0, 0, 1, 1, DRN, 0, 0, 24 + i, 7, 7));
    end
    for (int i = 0; i < 3; i++) begin
      apply($sformatf("halt%0d", i),
            mk(2'b00, 32'd88, 0, 5'd0, 5'd1, 0, 5'd2, 0, i == 1, i == 2, i != 0, 1, FROZEN,
               1, 0, 28, 7, 7));
    end

    // Drain aborted by a jump in the first drain cycle.
    reset_check("rst1");
    apply("ab0", mk(2'b00, 32'd84, 0, 5'd0, 5'd1, 0, 5'd2, 0, 0, 0, 1, 1, ALL, 0, 0, 0, 0, 0));
    apply("ab1", mk(2'b00, 32'd88, 0, 5'd0, 5'd1, 0, 5'd2, 0, 0, 0, 1, 1, ALL, 0, 0, 1, 0, 0));
    apply("ab2", mk(2'b00, 32'd88, 0, 5'd0, 5'd1, 0, 5'd2, 0, 1, 0, 1, 1, FL1, 0, 0, 2, 0, 0));
    apply("ab3", mk(2'b00, 32'd16, 0, 5'd0, 5'd1, 0, 5'd2, 0, 0, 0, 1, 1, ALL, 0, 0, 3, 0, 1));
    apply("ab4", mk(2'b00, 32'd16, 0, 5'd0, 5'd1, 0, 5'd2, 0, 0, 0, 1, 1, ALL, 0, 0, 4, 0, 1));

    // Reset mid-drain, then reset mid-wait.
    apply("md0", mk(2'b00, 32'd88, 0, 5'd0, 5'd1, 0, 5'd2, 0, 0, 0, 1, 1, ALL, 0, 0, 5, 0, 1));
    apply("md1", mk(2'b00, 32'd88, 0, 5'd0, 5'd1, 0, 5'd2, 0, 0, 0, 1, 1, DRN, 0, 0, 6, 0, 1));
    reset_check("rst2");
    apply("mr0", mk(2'b00, 32'd40, 0, 5'd0, 5'd1, 0, 5'd2, 0, 0, 0, 1, 1, ALL, 0, 0, 0, 0, 0));
    apply("mw0", mk(2'b00, 32'd40, 0, 5'd0, 5'd1, 0, 5'd2, 0, 0, 0, 0, 1, FROZEN, 0, 0, 1, 0, 0));
    reset_check("rst3");
    apply("mr1", mk(2'b00, 32'd40, 0, 5'd0, 5'd1, 0, 5'd2, 0, 0, 0, 1, 1, ALL, 0, 0, 0, 0, 0));
    apply("mr2", mk(2'b00, 32'd40, 0, 5'd0, 5'd1, 0, 5'd2, 0, 0, 0, 1, 1, ALL, 0, 0, 1, 0, 0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB). It generates the per-stage register write-enables and flush signals for:
- load-use stalls;
- control-flow redirects (jumps resolved in ID, branches resolved in EX) under the selected branch strategy;
- instruction/data memory wait states.
It also drains the pipeline and halts when fetch reaches a terminal PC, and keeps saturating performance counters.

Parameters:
HALT_PC, 32'd88, fetch address that triggers drain-and-halt
DRAIN_CYCLES, 4, cycles needed to empty ID..WB after fetch stops
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
bp_mode  in  2  00=not-taken, 10=delay slot, 01/11 unsupported (behave as 00)
fetch_pc  in  32  current PC register value
id_rs, id_rt  in  5 each  source registers of the instruction in ID
id_uses_rs, id_uses_rt  in  1 each  the instruction in ID reads rs / rt
id_jump  in  1  jump decoded in ID (redirect this cycle)
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination register of the instruction in EX
ex_branch_taken  in  1  branch in EX resolved taken (redirect this cycle)
imem_ready, dmem_ready  in  1 each  memory ready; low = wait
pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  stage-register enables
ifid_flush, idex_flush  out  1 each  load a bubble (NOP) into IF/ID or ID/EX
halted  out  1  pipeline drained at HALT_PC
bp_mode_err  out  1  bp_mode is 01 or 11
cnt_cycles, cnt_stalls, cnt_flushes  out  CNT_W each  performance counters

Behaviour:
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED.
- Reset (rst=0, async): state=RUN, drain counter=0, halted=0, all counters=0. All write-enables=1 and both flushes=0 while rst is low.
- Priority within a cycle: memory wait > redirect > load-use > drain entry.
- MEM_WAIT:
  - Entered from RUN or DRAIN, or held, whenever imem_ready=0 or dmem_ready=0.
  - All write-enables=0, flushes=0; pipeline frozen, so a pending branch or jump stays asserted.
  - Returns to the prior state the cycle both ready inputs are 1. Control-flow outputs for that cycle are evaluated normally.
- Load-use hazard:
  - Condition: ex_mem_read & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - Response: pc_we=0, ifid_we=0, idex_flush=1; other enables=1. Exactly one bubble.
  - Cannot coincide with ex_branch_taken, since EX holds a single instruction.
- Redirects:
  - ex_branch_taken, mode 00: ifid_flush=1, idex_flush=1 (2 bubbles).
  - ex_branch_taken, mode 10: ifid_flush=1 only; the delay-slot instruction in ID proceeds.
  - id_jump, mode 00: ifid_flush=1 (1 bubble).
  - id_jump, mode 10: no flush.
  - If both are set, ex_branch_taken wins (older instruction).
  - pc_we=1 so the PC mux loads the target.
- Drain:
  - Entry: in RUN, fetch_pc==HALT_PC with no wait, redirect or stall → DRAIN, counter=DRAIN_CYCLES.
  - In DRAIN: pc_we=0, ifid_flush=1, downstream enables=1. Counter decrements each non-wait cycle.
  - Any id_jump or ex_branch_taken in DRAIN aborts the drain: apply the redirect flushes, pc_we=1, state → RUN, counter cleared.
  - When the counter reaches 0 → HALTED.
- HALTED: all write-enables=0, flushes=0, halted=1. Sticky until reset.
- Counters (all saturate at 2^CNT_W−1; all freeze in HALTED):
  - cnt_cycles: +1 every cycle not in HALTED.
  - cnt_stalls: +1 per cycle in MEM_WAIT or with a load-use stall.
  - cnt_flushes: +1 per cycle with a redirect-caused flush. Drain bubbles do not count.
- bp_mode_err is combinational from bp_mode.
- Reset asserted mid-drain or mid-wait returns to RUN immediately, with no residual flush.

Decomposition:
- Package cpu_ctrl_pkg: state enum (RUN, MEM_WAIT, DRAIN, HALTED) and bp_mode constants (BP_NOT_TAKEN=2'b00, BP_TAKEN=2'b01, BP_DELAY_SLOT=2'b10).
- One sub-module: sat_counter (CNT_W-wide, enable, async active-low reset, saturating), instantiated three times.
- Hazard, redirect and FSM logic stay in the top module.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=20, id_rs=20, id_uses_rs=1 → one cycle of pc_we=0, ifid_we=0, idex_flush=1; cnt_stalls=1.
- Branch, mode 00 vs 10: ex_branch_taken=1 → mode 00 gives ifid_flush=1 and idex_flush=1; mode 10 gives ifid_flush=1 only. cnt_flushes=1 in each case.
- Jump during memory wait: id_jump=1 with imem_ready=0 for 3 cycles → all enables 0 for 3 cycles; on ready, ifid_flush=1 (mode 00); cnt_stalls=3.
- Drain/halt: fetch_pc=88 in RUN with no hazards → 4 cycles of pc_we=0, ifid_flush=1, then halted=1 and all enables 0; cnt_cycles frozen afterwards.
- Drain abort: id_jump=1 in the first DRAIN cycle (jump at 84 to 16) → ifid_flush=1, pc_we=1, state RUN, halted stays 0.
- Reset: rst=0 mid-DRAIN → immediately state RUN, counters 0, enables 1, flushes 0; bp_mode=01 → bp_mode_err=1 and behaviour identical to 00.
